// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state and direction encodings for param_counter.
package counter_pkg;
    typedef enum logic {RUN, DONE} state_e;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/counter_nxt.sv
// counter_nxt: next count (with wrap) and terminal-event flag for one enabled step.
module counter_nxt
    import counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             term_o
);
    // Counting up from above limit is a terminal event, never a run through 2^WIDTH.
    assign term_o = (up_i == DIR_UP) ? (count_i >= limit_i) : (count_i == '0);
    assign nxt_o  = term_o ? ((up_i == DIR_UP) ? '0 : limit_i)
                           : ((up_i == DIR_UP) ? count_i + 1'b1 : count_i - 1'b1);
endmodule

// File: rtl/param_counter.sv
// param_counter: up/down modulo counter with load, one-shot stop and terminal-count pulse.
module param_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, nxt;
    logic             tc_q, tc_d, term;

    counter_nxt #(.WIDTH(WIDTH)) u_nxt (
        .count_i(count_q),
        .limit_i(limit),
        .up_i   (up),
        .nxt_o  (nxt),
        .term_o (term)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
            state_d = RUN;
        end else if (en && state_q == RUN) begin
            tc_d    = term;
            count_d = (term && one_shot) ? count_q : nxt;
            state_d = (term && one_shot) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = (state_q == DONE);
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed vector table plus hand-written corner sequences, WIDTH=8.
module tb_param_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0, one_shot = 1'b0;
    logic [7:0] load_val = '0, limit = '0;
    logic [7:0] count;
    logic       tc, done;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct {
        logic       rst, en, up, ld;
        logic [7:0] lv, lim;
        logic       os;
        logic [7:0] ec;
        logic       et, ed;
    } vec_t;

    vec_t tbl[$];

    param_counter #(.WIDTH(8), .RST_VAL(8'd0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .limit(limit), .one_shot(one_shot),
        .count(count), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [7:0] lv,
                                logic [7:0] lim, logic os, logic [7:0] ec, logic et, logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.ld = l; v.lv = lv; v.lim = lim; v.os = os;
        v.ec = ec; v.et = et; v.ed = ed;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst; en = v.en; up = v.up; load = v.ld;
        load_val = v.lv; limit = v.lim; one_shot = v.os;
        @(posedge clk);
        #1;
        n_checks++;
        if (count !== v.ec || tc !== v.et || done !== v.ed) begin
            n_fail++;
            $display("FAIL %s: got count=%0d tc=%0b done=%0b, expected count=%0d tc=%0b done=%0b",
                     name, count, tc, done, v.ec, v.et, v.ed);
        end
    endtask

    initial begin
        //                rst en up ld  lv  lim os  cnt tc done
        tbl.push_back(mk(1, 1, 1, 1, 77,  5, 0,   0, 0, 0));
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 5, 0, 8'(i), 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  5, 0,   0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  5, 0,   1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  3,  9, 0,   3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  9, 0,   2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  9, 0,   1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  9, 0,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  9, 0,   9, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,  0,  9, 0,   8, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1,  0,  2, 1,   0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  2, 1,   1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  2, 1,   2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  2, 1,   2, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0,  0,  2, 1,   2, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  0,  2, 0,   2, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1,  0,  2, 1,   0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1,200, 10, 0, 200, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0, 10, 0,   0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 50, 10, 0,  50, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  5,  5, 0,   5, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0,  0,  5, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  2,  2, 1,   2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0,  0,  2, 1,   2, 1, 1));
        tbl.push_back(mk(1, 1, 1, 0,  0,  2, 1,   0, 0, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // limit=0: every enabled edge is terminal, both directions, count stays 0
        step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "lim0_load");
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0), "lim0_up_a");
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0), "lim0_up_b");
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "lim0_dn");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lim0_idle");
        // limit change takes effect on the very next edge
        step(mk(0, 1, 1, 0, 0, 3, 0, 1, 0, 0), "lim_chg_a");
        step(mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0), "lim_chg_b");
        // direction change is immediate: 0 counting down wraps to limit
        step(mk(0, 1, 0, 0, 0, 7, 0, 7, 1, 0), "dir_chg");
        // en low holds the count with no pulse
        step(mk(0, 0, 1, 0, 0, 7, 0, 7, 0, 0), "hold");
        // counting up from 255 is terminal, never overflows through 0 by carry
        step(mk(0, 0, 1, 1, 255, 7, 1, 255, 0, 0), "max_load");
        step(mk(0, 1, 1, 0, 0, 7, 1, 255, 1, 1), "max_stop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion before 100000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set counter, load and limit width (legal 2..64).
REQ-002 Parameter RST_VAL, default 0, SHALL be the count value forced by reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 en  input  1  count enable; no count change while low, except via load.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value loaded when load=1.
REQ-009 limit  input  WIDTH  modulus top; count range is 0..limit.
REQ-010 one_shot  input  1  1 = stop at terminal event, 0 = free-run with wrap.
REQ-011 count  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 done  output  1  registered; high while the FSM is in DONE.

Function
REQ-014 Priority SHALL be reset > load > en; simultaneous load and en loads and does not count.
REQ-015 The FSM SHALL have states RUN and DONE; reset and load both enter RUN.
REQ-016 In RUN with en=1 and up=1: count<limit -> count+1; count>=limit -> terminal event.
REQ-017 In RUN with en=1 and up=0: count>0 -> count-1; count==0 -> terminal event.
REQ-018 Terminal event with one_shot=0 SHALL wrap: up -> 0, down -> limit; FSM stays in RUN.
REQ-019 Terminal event with one_shot=1 SHALL hold count unchanged and move the FSM to DONE.
REQ-020 tc SHALL be 1 for exactly the cycle after a terminal-event edge, otherwise 0; it is never stretched.
REQ-021 In DONE, count SHALL hold and en SHALL be ignored; only load or reset leaves DONE.
REQ-022 Load SHALL set count=load_val, even when load_val>limit; tc=0 on that edge.
REQ-023 If count>limit while counting up, the next enabled edge SHALL be a terminal event, never a count through 2^WIDTH.
REQ-024 Changes to limit, up and one_shot SHALL take effect on the next edge without a pipeline delay.
REQ-025 limit=0 SHALL give a terminal event on every enabled edge, with count held at 0.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; no intermediate carry is exposed.

Reset
REQ-027 On reset: count=RST_VAL, tc=0, done=0, FSM=RUN, regardless of en or load.
REQ-028 Reset asserted mid-count or in DONE SHALL take effect on the same edge, with no residual tc pulse.

Structure
REQ-029 The FSM state enum (RUN, DONE) SHALL live in the shared package counter_pkg.
REQ-030 The direction encodings (DIR_UP=1, DIR_DN=0) SHALL also live in counter_pkg.
REQ-031 One combinational sub-module, counter_nxt, SHALL compute the next count and the terminal flag.
REQ-032 param_counter SHALL own all registers and the FSM.

Verification (WIDTH=8)
REQ-033 reset=1 for 1 cycle, then en=1, up=1, limit=5, one_shot=0 -> count 0,1,2,3,4,5,0; tc pulses once, in the cycle count returns to 0.
REQ-034 load=1 with load_val=3, then up=0, en=1, limit=9 -> count 3,2,1,0,9; tc high only with 9.
REQ-035 one_shot=1, limit=2, up=1, en=1 from 0 -> count 0,1,2, then holds 2; done=1, one tc; further en has no effect until load=1 with load_val=0 clears done.
REQ-036 load_val=200 with limit=10, up=1, en=1 -> count 200 then 0 with tc; load and en high together -> load wins.
REQ-037 reset=1 in the same cycle as a terminal event, and reset=1 while in DONE -> count=RST_VAL, tc=0, done=0 on that edge.
